vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_SYNC, default 128: horizontal sync width, pixels.
REQ-002 Parameter H_BP, default 88: horizontal back porch, pixels (H_SYNC+H_BP = 216 = first visible column).
REQ-003 Parameter H_VIS, default 800: visible columns.
REQ-004 Parameter H_FP, default 40: horizontal front porch; H_TOTAL = sum = 1056.
REQ-005 Parameter V_SYNC, default 2: vertical sync width, lines.
REQ-006 Parameter V_BP, default 33: vertical back porch (V_SYNC+V_BP = 35 = first visible row).
REQ-007 Parameter V_VIS, default 600: visible rows.
REQ-008 Parameter V_FP, default 1: vertical front porch; V_TOTAL = sum = 636.
REQ-009 Parameter SYNC_POL, default 1: active level of hsync/vsync.
REQ-010 clk  input  1  pixel-domain clock.
REQ-011 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-012 ce  input  1  pixel enable; counters advance only on clk rising edge with ce=1.
REQ-013 Columnas  output  11  current column count, 0..H_TOTAL-1.
REQ-014 Filas  output  10  current row count, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync.
REQ-016 vsync  output  1  vertical sync.
REQ-017 video_on  output  1  pixel inside visible area.
REQ-018 img_on  output  1  pixel inside 512x256 image window fed to the address stage.
REQ-019 frame_start  output  1  one-clock pulse at frame wrap.

Function
REQ-020 Columnas, Filas, hsync, vsync, video_on, img_on SHALL all be registers; flags SHALL always describe the Columnas/Filas value currently presented (no skew).
REQ-021 With ce=1: Columnas SHALL increment by 1; at H_TOTAL-1 SHALL wrap to 0 and Filas SHALL advance the same cycle.
REQ-022 Filas SHALL increment only at Columnas wrap; at V_TOTAL-1 with Columnas wrap SHALL wrap to 0.
REQ-023 With ce=0: all registered outputs SHALL hold; frame_start SHALL be 0.
REQ-024 hsync SHALL equal SYNC_POL when Columnas < H_SYNC, else ~SYNC_POL.
REQ-025 vsync SHALL equal SYNC_POL when Filas < V_SYNC, else ~SYNC_POL.
REQ-026 video_on SHALL be 1 iff 216 <= Columnas < 1016 and 35 <= Filas < 635 (parameter-derived bounds).
REQ-027 img_on SHALL be 1 iff 216 <= Columnas < 728 and 35 <= Filas < 291 (first 512 columns, first 256 rows of visible area), so downstream (Filas-35, Columnas-216) fits 8+9 bits.
REQ-028 img_on SHALL imply video_on.
REQ-029 frame_start SHALL be a registered pulse, high for exactly one clk cycle following the ce edge on which (Columnas,Filas) become (0,0).
REQ-030 Counter arithmetic SHALL use terminal-count compare, never rely on natural binary overflow.

Reset
REQ-031 While rst=1 (asynchronously): Columnas=0, Filas=0, hsync=SYNC_POL, vsync=SYNC_POL, video_on=0, img_on=0, frame_start=0.
REQ-032 Reset asserted mid-line/mid-frame SHALL abort the frame; first ce after release SHALL give Columnas=1, Filas=0.
REQ-033 frame_start SHALL NOT pulse on reset release.

Verification
REQ-034 rst, release, ce=1 for 216 edges -> Columnas=216, Filas=0, hsync inactive from Columnas=128, video_on=0 (row 0).
REQ-035 Run to Columnas=1055, Filas=34, one ce -> Columnas=0, Filas=35; further 216 edges -> video_on=1, img_on=1.
REQ-036 At Filas=35: Columnas=727 -> img_on=1; Columnas=728 -> img_on=0, video_on=1; Columnas=1016 -> video_on=0.
REQ-037 Full frame (1056x636 ce edges) -> exactly one frame_start pulse, count returns to (0,0); vsync active for Filas 0..1 only.
REQ-038 Toggle ce 1/0 alternately -> counters advance every second clk, outputs stable while ce=0, frame period doubles.
REQ-039 Assert rst at Columnas=500, Filas=300 without clk edge -> outputs at reset values immediately; no frame_start after release.

Source files
------------

// File: rtl/vga_sync.sv
// VGA timing generator: column/row counters with registered sync, visible-area,
// image-window and frame-start flags, all aligned to the presented count.
module vga_sync #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned H_VIS    = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_VIS    = 600,
    parameter int unsigned V_FP     = 1,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] Columnas,
    output logic [9:0]  Filas,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        img_on,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int unsigned H_IMG   = (H_VIS < 512) ? H_VIS : 512;
    localparam int unsigned V_IMG   = (V_VIS < 256) ? V_VIS : 256;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
    localparam logic [10:0] H_VIS_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_HI = 11'(H_SYNC + H_BP + H_VIS);
    localparam logic [10:0] H_IMG_HI = 11'(H_SYNC + H_BP + H_IMG);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VIS_HI = 10'(V_SYNC + V_BP + V_VIS);
    localparam logic [9:0]  V_IMG_HI = 10'(V_SYNC + V_BP + V_IMG);

    logic [10:0] col_next;
    logic [9:0]  row_next;
    logic        h_vis_next;
    logic        v_vis_next;
    logic        h_img_next;
    logic        v_img_next;
    logic        wrap_next;

    always_comb begin
        col_next = Columnas;
        row_next = Filas;
        if (Columnas == H_LAST) begin
            col_next = '0;
            if (Filas == V_LAST) begin
                row_next = '0;
            end else begin
                row_next = Filas + 10'd1;
            end
        end else begin
            col_next = Columnas + 11'd1;
        end
    end

    // Flags are decoded from the next count so they land in the same register
    // stage as the count they describe.
    always_comb begin
        h_vis_next = (col_next >= H_VIS_LO) && (col_next < H_VIS_HI);
        v_vis_next = (row_next >= V_VIS_LO) && (row_next < V_VIS_HI);
        h_img_next = (col_next >= H_VIS_LO) && (col_next < H_IMG_HI);
        v_img_next = (row_next >= V_VIS_LO) && (row_next < V_IMG_HI);
        wrap_next  = (col_next == '0) && (row_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Columnas    <= '0;
            Filas       <= '0;
            hsync       <= SYNC_POL;
            vsync       <= SYNC_POL;
            video_on    <= 1'b0;
            img_on      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce) begin
                Columnas    <= col_next;
                Filas       <= row_next;
                hsync       <= (col_next < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (row_next < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
                video_on    <= h_vis_next && v_vis_next;
                img_on      <= h_img_next && v_img_next;
                frame_start <= wrap_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: default-timing instance plus a reduced-timing
// instance (inverted sync polarity) used for full-frame and ce-toggle runs.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, ce_a, rst_b, ce_b;
    logic [10:0] col_a, col_b;
    logic [9:0]  row_a, row_b;
    logic        hs_a, vs_a, vid_a, img_a, fs_a;
    logic        hs_b, vs_b, vid_b, img_b, fs_b;

    vga_sync dut_a (
        .clk(clk), .rst(rst_a), .ce(ce_a),
        .Columnas(col_a), .Filas(row_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vid_a), .img_on(img_a),
        .frame_start(fs_a)
    );

    // 19 x 10 frame: visible cols 7..16, rows 4..8; sync active low.
    vga_sync #(
        .H_SYNC(4), .H_BP(3), .H_VIS(10), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b),
        .Columnas(col_b), .Filas(row_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vid_b), .img_on(img_b),
        .frame_start(fs_b)
    );

    typedef struct {
        bit    sel;
        string name;
        int    col;
        int    row;
        bit    hs, vs, vid, img, fs;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void cmp(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    task automatic expect_a(string n, int c, int r, bit hs, bit vs, bit vid, bit img, bit fs);
        exp_t e;
        e.sel = 1'b0; e.name = n; e.col = c; e.row = r;
        e.hs = hs; e.vs = vs; e.vid = vid; e.img = img; e.fs = fs;
        sb.push_back(e);
    endtask

    task automatic expect_b(string n, int c, int r, bit hs, bit vs, bit vid, bit img, bit fs);
        exp_t e;
        e.sel = 1'b1; e.name = n; e.col = c; e.row = r;
        e.hs = hs; e.vs = vs; e.vid = vid; e.img = img; e.fs = fs;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: pops every expectation queued by the driver and
    // compares it with the selected instance, away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                cmp({e.name, ".col"}, int'(col_a), e.col);
                cmp({e.name, ".row"}, int'(row_a), e.row);
                cmp({e.name, ".hsync"}, int'(hs_a), int'(e.hs));
                cmp({e.name, ".vsync"}, int'(vs_a), int'(e.vs));
                cmp({e.name, ".video_on"}, int'(vid_a), int'(e.vid));
                cmp({e.name, ".img_on"}, int'(img_a), int'(e.img));
                cmp({e.name, ".frame_start"}, int'(fs_a), int'(e.fs));
            end else begin
                cmp({e.name, ".col"}, int'(col_b), e.col);
                cmp({e.name, ".row"}, int'(row_b), e.row);
                cmp({e.name, ".hsync"}, int'(hs_b), int'(e.hs));
                cmp({e.name, ".vsync"}, int'(vs_b), int'(e.vs));
                cmp({e.name, ".video_on"}, int'(vid_b), int'(e.vid));
                cmp({e.name, ".img_on"}, int'(img_b), int'(e.img));
                cmp({e.name, ".frame_start"}, int'(fs_b), int'(e.fs));
            end
        end
    end

    // Window statistics for instance B and global invariants for instance A.
    logic        win_b = 1'b0;
    logic        ce_last_b = 1'b0;
    logic [24:0] prev_b = '0;
    int          vs_cnt = 0, hs_cnt = 0, fs_cnt = 0, hold_err = 0;
    int          fs_cnt_a = 0, imp_err = 0;

    always @(posedge clk) ce_last_b <= ce_b;

    always @(negedge clk) begin
        #1;
        if (win_b) begin
            if (ce_last_b) begin
                if (vs_b == 1'b0) vs_cnt++;
                if (hs_b == 1'b0) hs_cnt++;
                if (fs_b) fs_cnt++;
            end else if ({col_b, row_b, hs_b, vs_b, vid_b, img_b} != prev_b || fs_b) begin
                hold_err++;
            end
        end
        prev_b = {col_b, row_b, hs_b, vs_b, vid_b, img_b};
        if (img_a && !vid_a) imp_err++;
        if (fs_a) fs_cnt_a++;
    end

    task automatic run_a(int n);
        repeat (n) begin @(negedge clk); ce_a = 1'b1; end
        @(negedge clk); ce_a = 1'b0;
    endtask

    task automatic run_b(int n);
        repeat (n) begin @(negedge clk); ce_b = 1'b1; end
        @(negedge clk); ce_b = 1'b0;
    endtask

    task automatic toggle_b(int n);
        repeat (n) begin
            @(negedge clk); ce_b = 1'b0;
            @(negedge clk); ce_b = 1'b1;
        end
        @(negedge clk); ce_b = 1'b0;
    endtask

    task automatic clear_stats();
        vs_cnt = 0; hs_cnt = 0; fs_cnt = 0; hold_err = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b0; ce_b = 1'b0;
        repeat (2) @(negedge clk);
        expect_a("a_reset", 0, 0, 1, 1, 0, 0, 0);
        expect_b("b_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;

        // Default timing: horizontal sync edge and visible-area boundaries.
        run_a(127);   expect_a("a_col127", 127, 0, 1, 1, 0, 0, 0);
        run_a(1);     expect_a("a_col128", 128, 0, 0, 1, 0, 0, 0);
        run_a(88);    expect_a("a_col216_row0", 216, 0, 0, 1, 0, 0, 0);
        run_a(36743); expect_a("a_col1055_row34", 1055, 34, 0, 0, 0, 0, 0);
        run_a(1);     expect_a("a_wrap_row35", 0, 35, 1, 0, 0, 0, 0);
        run_a(216);   expect_a("a_vis_start", 216, 35, 0, 0, 1, 1, 0);
        run_a(511);   expect_a("a_col727", 727, 35, 0, 0, 1, 1, 0);
        run_a(1);     expect_a("a_col728", 728, 35, 0, 0, 1, 0, 0);
        run_a(287);   expect_a("a_col1015", 1015, 35, 0, 0, 1, 0, 0);
        run_a(1);     expect_a("a_col1016", 1016, 35, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        expect_a("a_hold_ce0", 1016, 35, 0, 0, 0, 0, 0);
        run_a(540);   expect_a("a_mid_frame", 500, 36, 0, 0, 1, 1, 0);

        // Asynchronous reset between clock edges, then release.
        @(negedge clk); rst_a = 1'b1;
        expect_a("a_async_rst", 0, 0, 1, 1, 0, 0, 0);
        repeat (3) begin @(negedge clk); ce_a = 1'b1; end
        @(negedge clk); ce_a = 1'b0; rst_a = 1'b0;
        expect_a("a_rst_release", 0, 0, 1, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        expect_a("a_no_fs_after_rst", 0, 0, 1, 1, 0, 0, 0);
        run_a(1);     expect_a("a_first_ce", 1, 0, 1, 1, 0, 0, 0);

        // Reduced timing: one full frame at ce=1.
        @(negedge clk); clear_stats(); win_b = 1'b1;
        run_b(190);   expect_b("b_frame_wrap", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); win_b = 1'b0;
        cmp("b_frame_fs_pulses", fs_cnt, 1);
        cmp("b_frame_vsync_cycles", vs_cnt, 38);
        cmp("b_frame_hsync_cycles", hs_cnt, 40);
        cmp("b_frame_hold_err", hold_err, 0);

        run_b(83);    expect_b("b_vis_start", 7, 4, 1, 1, 1, 1, 0);
        run_b(10);    expect_b("b_vis_end", 17, 4, 1, 1, 0, 0, 0);
        run_b(97);    expect_b("b_frame_wrap2", 0, 0, 0, 0, 0, 0, 1);

        // Alternating ce: one frame now spans twice as many clocks.
        @(negedge clk); clear_stats(); win_b = 1'b1;
        toggle_b(10);  expect_b("b_toggle_mid", 10, 0, 1, 0, 0, 0, 0);
        toggle_b(180); expect_b("b_toggle_wrap", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); win_b = 1'b0;
        cmp("b_toggle_fs_pulses", fs_cnt, 1);
        cmp("b_toggle_vsync_cycles", vs_cnt, 38);
        cmp("b_toggle_hsync_cycles", hs_cnt, 40);
        cmp("b_toggle_hold_err", hold_err, 0);

        repeat (2) @(negedge clk);
        cmp("a_frame_start_pulses", fs_cnt_a, 0);
        cmp("a_img_outside_video", imp_err, 0);
        cmp("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
